reqrsp_mem_responder: RTL

Responder-side endpoint for the two-channel request/response bus: a flip-flop word memory that accepts reads, byte-strobed writes and atomic fetch-and-op requests on the Q channel and returns one response per request on the P channel. It terminates a request/response link in testbenches and small on-cluster scratch/peripheral regions. It is the slave counterpart to bus initiators such as cores, DMA engines and bus adapters.

---
 rtl/reqrsp_pkg.sv | 22 ++
 rtl/reqrsp_amo_alu.sv | 30 +++
 rtl/reqrsp_mem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/reqrsp_pkg.sv
// Shared request/response bus types: atomic opcodes and access size encoding.
package reqrsp_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

  // log2 of the number of bytes in an access
  typedef logic [2:0] size_t;

endpackage

// File: rtl/reqrsp_amo_alu.sv
// Combinational AMO ALU: computes the word written back by an atomic op.
module reqrsp_amo_alu
  import reqrsp_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  amo_op_e              amo_op,
  input  logic [DataWidth-1:0] old_data,
  input  logic [DataWidth-1:0] operand,
  output logic [DataWidth-1:0] new_data
);

  always_comb begin
    // NOTE: default first so every path assigns new_data; no latch is inferred.
    new_data = old_data;
    case (amo_op)
      AMOSwap: new_data = operand;
      AMOAdd:  new_data = old_data + operand;
      AMOAnd:  new_data = old_data & operand;
      AMOOr:   new_data = old_data | operand;
      AMOXor:  new_data = old_data ^ operand;
      AMOMax:  new_data = ($signed(old_data) > $signed(operand)) ? old_data : operand;
      AMOMin:  new_data = ($signed(old_data) < $signed(operand)) ? old_data : operand;
      AMOMaxu: new_data = (old_data > operand) ? old_data : operand;
      AMOMinu: new_data = (old_data < operand) ? old_data : operand;
      default: new_data = old_data;
    endcase
  end

endmodule

// File: rtl/reqrsp_mem_responder.sv
// Flip-flop word memory terminating a reqrsp link: reads, strobed writes, atomics.
// Atomic support is built only when REQRSP_MEM_RESPONDER_AMO_EN is defined.
module reqrsp_mem_responder
  import reqrsp_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   q_addr_i,
  input  logic                   q_write_i,
  input  amo_op_e                q_amo_i,
  input  logic [DataWidth-1:0]   q_data_i,
  input  logic [DataWidth/8-1:0] q_strb_i,
  input  size_t                  q_size_i,
  input  logic                   q_valid_i,
  output logic                   q_ready_o,
  output logic [DataWidth-1:0]   p_data_o,
  output logic                   p_error_o,
  output logic                   p_valid_o,
  input  logic                   p_ready_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned WordOff   = $clog2(StrbWidth);
  localparam int unsigned IdxWidth  = $clog2(NumWords);
  localparam logic [63:0] MemBytes  = 64'(NumWords) * 64'(StrbWidth);

  typedef enum logic {Idle, AmoExec} state_e;

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  mem_q [NumWords];
  logic [DataWidth-1:0]  rsp_data_q;
  logic                  rsp_error_q, rsp_valid_q;

  logic [IdxWidth-1:0]   req_idx;
  logic [DataWidth-1:0]  rd_word, wr_word;
  logic                  is_amo, addr_err, size_err, amo_err, req_err;
  logic                  q_hs, amo_start;

  assign req_idx  = q_addr_i[WordOff +: IdxWidth];
  assign rd_word  = mem_q[req_idx];
  assign is_amo   = (q_amo_i != AMONone);
  assign addr_err = (64'(q_addr_i) >= MemBytes);
  assign size_err = (q_size_i > size_t'(WordOff));
  assign req_err  = addr_err || size_err || amo_err;
  assign q_hs     = q_valid_i && q_ready_o;

`ifdef REQRSP_MEM_RESPONDER_AMO_EN
  logic [IdxWidth-1:0]  amo_idx_q;
  logic [DataWidth-1:0] amo_operand_q, amo_old_q, amo_result;
  amo_op_e              amo_op_q;

  // Atomics must be full-word; LR/SC reservations are not supported here.
  assign amo_err = is_amo && ((q_size_i != size_t'(WordOff)) ||
                              (q_amo_i == AMOLR) || (q_amo_i == AMOSC));

  reqrsp_amo_alu #(
    .DataWidth(DataWidth)
  ) i_amo_alu (
    .amo_op  (amo_op_q),
    .old_data(amo_old_q),
    .operand (amo_operand_q),
    .new_data(amo_result)
  );
`else
  assign amo_err = is_amo;
`endif

  always_comb begin
    for (int b = 0; b < StrbWidth; b++) begin
      wr_word[8*b +: 8] = q_strb_i[b] ? q_data_i[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    q_ready_o = 1'b0;
    amo_start = 1'b0;
    case (state_q)
      Idle: begin
        q_ready_o = !rsp_valid_q || p_ready_i;
`ifdef REQRSP_MEM_RESPONDER_AMO_EN
        if (q_valid_i && q_ready_o && is_amo && !req_err) begin
          amo_start = 1'b1;
          state_d   = AmoExec;
        end
`endif
      end
      AmoExec: state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the memory is reset explicitly because reads after reset must return zero.
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef REQRSP_MEM_RESPONDER_AMO_EN
      amo_idx_q     <= '0;
      amo_operand_q <= '0;
      amo_old_q     <= '0;
      amo_op_q      <= AMONone;
`endif
    end else begin
      if (rsp_valid_q && p_ready_i) rsp_valid_q <= 1'b0;

      // A new load in the same cycle overrides the retire above: no bubble.
      if (q_hs && !amo_start) begin
        rsp_valid_q <= 1'b1;
        rsp_error_q <= req_err;
        rsp_data_q  <= req_err ? '0 : rd_word;
        if (!req_err && !is_amo && q_write_i) mem_q[req_idx] <= wr_word;
      end

`ifdef REQRSP_MEM_RESPONDER_AMO_EN
      if (amo_start) begin
        amo_idx_q     <= req_idx;
        amo_operand_q <= q_data_i;
        amo_old_q     <= rd_word;
        amo_op_q      <= q_amo_i;
      end

      if (state_q == AmoExec) begin
        mem_q[amo_idx_q] <= amo_result;
        rsp_valid_q      <= 1'b1;
        rsp_error_q      <= 1'b0;
        rsp_data_q       <= amo_old_q;
      end
`endif
    end
  end

  assign p_data_o  = rsp_data_q;
  assign p_error_o = rsp_error_q;
  assign p_valid_o = rsp_valid_q;

endmodule
